sprinkler_sched: RTL

Downstream consumer of the gps block's time_out/data_valid_out. Validates the 6-char ASCII UTC time (HHMMSS), converts it to local seconds-of-day, and runs a daily watering cycle. At a programmed local start minute, the cycle opens NUM_ZONES valves one at a time, each for ZONE_MINUTES, and closes everything if GPS time stops arriving.

---
 rtl/sprinkler_sched_if.sv | 36 +++
 rtl/sprinkler_sched.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sprinkler_sched_if.sv
// Bundles the GPS time feed, the manual stop and the valve/status outputs of sprinkler_sched.
// The master modport drives the time feed and stop; the slave modport is the scheduler side.
interface sprinkler_sched_if #(
    parameter int unsigned NUM_ZONES = 4
);
    logic                 time_valid;
    logic [47:0]          time_in;
    logic                 stop;
    logic [NUM_ZONES-1:0] valve;
    logic                 active;
    logic [2:0]           zone;
    logic                 time_err;
    logic                 fault;

    modport master (
        output time_valid,
        output time_in,
        output stop,
        input  valve,
        input  active,
        input  zone,
        input  time_err,
        input  fault
    );

    modport slave (
        input  time_valid,
        input  time_in,
        input  stop,
        output valve,
        output active,
        output zone,
        output time_err,
        output fault
    );
endinterface

// File: rtl/sprinkler_sched.sv
// Daily irrigation scheduler driven by ASCII UTC time samples: validate, convert to local
// seconds-of-day, then open the zone valves one at a time from a programmed start minute.
module sprinkler_sched #(
    parameter int unsigned NUM_ZONES      = 4,
    parameter int unsigned ZONE_MINUTES   = 10,
    parameter int unsigned START_HOUR     = 6,
    parameter int unsigned START_MIN      = 0,
    parameter int          TZ_OFFSET      = -5,
    parameter int unsigned TIMEOUT_CYCLES = 200000000
) (
    input logic              clk,
    input logic              rst_n,
    sprinkler_sched_if.slave bus
);
    localparam int          DaySec   = 86400;
    localparam int          TzSec    = TZ_OFFSET * 3600;
    localparam logic [16:0] DayCnt   = 17'd86400;
    localparam logic [16:0] StartSod = 17'(START_HOUR * 3600 + START_MIN * 60);
    localparam logic [16:0] StartEnd = 17'(START_HOUR * 3600 + START_MIN * 60 + 59);
    localparam logic [16:0] ZoneSec  = 17'(ZONE_MINUTES * 60);
    localparam logic [2:0]  LastZone = 3'(NUM_ZONES - 1);
    localparam logic [31:0] WdLast   = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWater,
        StFault
    } state_e;

    // Stage 1: raw sample capture
    logic        v1_q, v1_d;
    logic [47:0] raw1_q, raw1_d;

    // Stage 2: validated UTC seconds-of-day
    logic        v2_q, v2_d;
    logic [16:0] utc_q, utc_d;
    logic        time_err_q, time_err_d;

    // Stage 3: local seconds-of-day
    logic        v3_q, v3_d;
    logic [16:0] local_q, local_d;

    logic [31:0] wd_q, wd_d;

    state_e               state_q, state_d;
    logic [NUM_ZONES-1:0] valve_q, valve_d;
    logic                 active_q, active_d;
    logic [2:0]           zone_q, zone_d;
    logic [16:0]          zone_t0_q, zone_t0_d;
    logic                 run_done_q, run_done_d;
    logic                 fault_q, fault_d;

    logic [3:0]  dig [6];
    logic [6:0]  hh, mm, ss;
    logic        fmt_ok;
    logic        sample_ok;
    int          sod_sum;
    logic        in_start;
    logic [16:0] elapsed;
    logic        wd_trip;

    assign v1_d   = bus.time_valid;
    assign raw1_d = bus.time_in;

    // Byte 5 is the hour tens digit, byte 0 the second units digit.
    always_comb begin
        fmt_ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            dig[i] = raw1_q[8*i +: 4];
            if (raw1_q[8*i +: 8] < 8'h30 || raw1_q[8*i +: 8] > 8'h39) begin
                fmt_ok = 1'b0;
            end
        end
        hh = 7'(dig[5]) * 7'd10 + 7'(dig[4]);
        mm = 7'(dig[3]) * 7'd10 + 7'(dig[2]);
        ss = 7'(dig[1]) * 7'd10 + 7'(dig[0]);
        if (hh > 7'd23 || mm > 7'd59 || ss > 7'd59) begin
            fmt_ok = 1'b0;
        end
    end

    assign sample_ok  = v1_q & fmt_ok;
    assign time_err_d = v1_q & ~fmt_ok;
    assign v2_d       = sample_ok;
    assign utc_d      = 17'(hh) * 17'd3600 + 17'(mm) * 17'd60 + 17'(ss);

    // The offset is at most one day away, so one conditional correction brings it in range.
    always_comb begin
        sod_sum = $signed({15'd0, utc_q}) + TzSec;
        if (sod_sum < 0) begin
            sod_sum = sod_sum + DaySec;
        end else if (sod_sum >= DaySec) begin
            sod_sum = sod_sum - DaySec;
        end
        local_d = sod_sum[16:0];
    end

    assign v3_d = v2_q;

    always_comb begin
        if (sample_ok) begin
            wd_d = '0;
        end else if (&wd_q) begin
            wd_d = wd_q;
        end else begin
            wd_d = wd_q + 32'd1;
        end
    end

    assign wd_trip  = (wd_q == WdLast);
    assign in_start = (local_q >= StartSod) && (local_q <= StartEnd);
    // Modulo-2^17 arithmetic keeps the midnight-wrapped difference exact.
    assign elapsed  = (local_q >= zone_t0_q) ? (local_q - zone_t0_q)
                                             : (local_q + DayCnt - zone_t0_q);

    always_comb begin
        state_d    = state_q;
        valve_d    = valve_q;
        active_d   = active_q;
        zone_d     = zone_q;
        zone_t0_d  = zone_t0_q;
        run_done_d = run_done_q;
        fault_d    = fault_q;

        if (bus.stop) begin
            state_d  = StIdle;
            valve_d  = '0;
            active_d = 1'b0;
            zone_d   = '0;
        end else if (state_q == StWater && wd_trip) begin
            state_d  = StFault;
            valve_d  = '0;
            active_d = 1'b0;
            zone_d   = '0;
            fault_d  = 1'b1;
        end else if (v3_q) begin
            fault_d = 1'b0;
            case (state_q)
                StIdle: begin
                    if (in_start && !run_done_q) begin
                        state_d    = StWater;
                        zone_d     = '0;
                        zone_t0_d  = local_q;
                        valve_d    = NUM_ZONES'(1);
                        active_d   = 1'b1;
                        run_done_d = 1'b1;
                    end else if (!in_start) begin
                        run_done_d = 1'b0;
                    end
                end
                StWater: begin
                    if (elapsed >= ZoneSec) begin
                        if (zone_q < LastZone) begin
                            zone_d    = zone_q + 3'd1;
                            zone_t0_d = local_q;
                            valve_d   = valve_q << 1;
                        end else begin
                            state_d  = StIdle;
                            valve_d  = '0;
                            active_d = 1'b0;
                            zone_d   = '0;
                        end
                    end
                end
                StFault: begin
                    state_d = StIdle;
                    if (!in_start) begin
                        run_done_d = 1'b0;
                    end
                end
                default: begin
                    state_d  = StIdle;
                    valve_d  = '0;
                    active_d = 1'b0;
                    zone_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q       <= 1'b0;
            raw1_q     <= '0;
            v2_q       <= 1'b0;
            utc_q      <= '0;
            time_err_q <= 1'b0;
            v3_q       <= 1'b0;
            local_q    <= '0;
            wd_q       <= '0;
            state_q    <= StIdle;
            valve_q    <= '0;
            active_q   <= 1'b0;
            zone_q     <= '0;
            zone_t0_q  <= '0;
            run_done_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            v1_q       <= v1_d;
            raw1_q     <= raw1_d;
            v2_q       <= v2_d;
            utc_q      <= utc_d;
            time_err_q <= time_err_d;
            v3_q       <= v3_d;
            local_q    <= local_d;
            wd_q       <= wd_d;
            state_q    <= state_d;
            valve_q    <= valve_d;
            active_q   <= active_d;
            zone_q     <= zone_d;
            zone_t0_q  <= zone_t0_d;
            run_done_q <= run_done_d;
            fault_q    <= fault_d;
        end
    end

    assign bus.valve    = valve_q;
    assign bus.active   = active_q;
    assign bus.zone     = zone_q;
    assign bus.time_err = time_err_q;
    assign bus.fault    = fault_q;
endmodule
